// File: rtl/dmux16.sv
// dmux16: 1-to-16 registered demultiplexer; routes d0 to output z[sel], all others 0.
// Latency: one clock. Inputs sampled at edge k appear on the outputs after edge k.
// Backpressure: none. There is no handshake or enable, and new inputs are accepted every cycle.
//
// Ports:
//   clk        rising-edge clock
//   rstn       synchronous active-low reset; forces all outputs to 0
//   s3..s0     select bits; sel = {s3,s2,s1,s0}
//   d0         data bit routed to the selected output
//   z0..z15    registered outputs; zN is the output for select value N
module dmux16 (
  input  logic clk,
  input  logic rstn,
  input  logic s0,
  input  logic s1,
  input  logic s2,
  input  logic s3,
  input  logic d0,
  output logic z0,
  output logic z1,
  output logic z2,
  output logic z3,
  output logic z4,
  output logic z5,
  output logic z6,
  output logic z7,
  output logic z8,
  output logic z9,
  output logic z10,
  output logic z11,
  output logic z12,
  output logic z13,
  output logic z14,
  output logic z15
);

  logic [3:0]  sel;
  logic [15:0] z_d;
  logic [15:0] z_q;

  assign sel = {s3, s2, s1, s0};

  // Every output is cleared on every edge except the selected one.
  // A change of selection therefore clears the previous output and sets the
  // new one on the same edge, with no cycle where both are 1.
  always_comb begin
    z_d      = '0;
    z_d[sel] = d0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      z_q <= '0;
    end else begin
      z_q <= z_d;
    end
  end

  assign z0  = z_q[0];
  assign z1  = z_q[1];
  assign z2  = z_q[2];
  assign z3  = z_q[3];
  assign z4  = z_q[4];
  assign z5  = z_q[5];
  assign z6  = z_q[6];
  assign z7  = z_q[7];
  assign z8  = z_q[8];
  assign z9  = z_q[9];
  assign z10 = z_q[10];
  assign z11 = z_q[11];
  assign z12 = z_q[12];
  assign z13 = z_q[13];
  assign z14 = z_q[14];
  assign z15 = z_q[15];

endmodule

// File: tb/tb_dmux16.sv
// tb_dmux16: scoreboard bench for dmux16.
// Stimulus is driven at the falling edge, and the expected output for each rising edge is queued.
// A monitor 1 ns after each rising edge pops the queue and compares the result with the outputs.
module tb_dmux16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic s0 = 1'b0, s1 = 1'b0, s2 = 1'b0, s3 = 1'b0, d0 = 1'b0;
  logic z0, z1, z2, z3, z4, z5, z6, z7, z8, z9, z10, z11, z12, z13, z14, z15;
  logic [15:0] zv;

  int errors = 0;
  int checks = 0;
  int pushes = 0;
  int pops   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_exp = 16'h0000;

  always #5 clk = ~clk;

  dmux16 dut (
    .clk(clk), .rstn(rstn),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .d0(d0),
    .z0(z0), .z1(z1), .z2(z2), .z3(z3), .z4(z4), .z5(z5), .z6(z6), .z7(z7),
    .z8(z8), .z9(z9), .z10(z10), .z11(z11), .z12(z12), .z13(z13), .z14(z14), .z15(z15)
  );

  assign zv = {z15, z14, z13, z12, z11, z10, z9, z8, z7, z6, z5, z4, z3, z2, z1, z0};

  function automatic logic [15:0] model(input logic r, input logic [3:0] sel, input logic d);
    logic [15:0] one;
    one = 16'h0001;
    if (!r) return 16'h0000;
    return d ? (one << sel) : 16'h0000;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: outputs z15..z0 = %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] sel, input logic d);
    rstn = r;
    {s3, s2, s1, s0} = sel;
    d0 = d;
  endtask

  // Apply one input set for exactly one rising edge and queue its expected result.
  task automatic step(input logic r, input logic [3:0] sel, input logic d);
    @(negedge clk);
    drive(r, sel, d);
    @(posedge clk);
    last_exp = model(r, sel, d);
    exp_q.push_back(last_exp);
    pushes++;
  endtask

  // Monitor: one expected value per rising edge once stimulus has begun.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      check("edge", zv, exp_q.pop_front());
      pops++;
    end
  end

  // Toggle inputs between edges and confirm that the outputs hold; the last pattern is captured by the next edge.
  logic [4:0] toggles [4];
  initial begin
    toggles[0] = 5'b1010_1;
    toggles[1] = 5'b0101_0;
    toggles[2] = 5'b1111_1;
    toggles[3] = 5'b0110_1;
  end

  task automatic stability();
    logic [15:0] hold;
    hold = last_exp;
    for (int k = 0; k < 4; k++) begin
      #2;
      drive(1'b1, toggles[k][4:1], toggles[k][0]);
      #0.1;
      check("stable", zv, hold);
    end
    @(posedge clk);
    last_exp = model(1'b1, toggles[3][4:1], toggles[3][0]);
    exp_q.push_back(last_exp);
    pushes++;
  endtask

  initial begin
    // Reset held for two edges with a live select and data value.
    step(1'b0, 4'd5, 1'b1);
    step(1'b0, 4'd5, 1'b1);

    // Full sweep: d0=0 then d0=1 for every select value.
    for (int s = 0; s < 16; s++) begin
      step(1'b1, 4'(s), 1'b0);
      step(1'b1, 4'(s), 1'b1);
    end

    // Back-to-back selection change.
    step(1'b1, 4'd3, 1'b1);
    step(1'b1, 4'd12, 1'b1);

    // Wrap from 15 to 0.
    step(1'b1, 4'd15, 1'b1);
    step(1'b1, 4'd0, 1'b1);

    // Reset mid-operation; a low rstn without an edge must not disturb z9.
    step(1'b1, 4'd9, 1'b1);
    @(negedge clk);
    drive(1'b0, 4'd9, 1'b1);
    #2;
    check("rst_no_edge", zv, 16'h0200);
    @(posedge clk);
    last_exp = 16'h0000;
    exp_q.push_back(last_exp);
    pushes++;
    step(1'b1, 4'd9, 1'b1);

    // Input activity between edges.
    step(1'b1, 4'd6, 1'b1);
    stability();
    step(1'b1, 4'd7, 1'b0);
    stability();
    step(1'b1, 4'd1, 1'b1);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (pops != pushes || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: popped %0d of %0d expected values, %0d left", pops, pushes, exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
